// File: rtl/bcd_pkg.sv
// Shared types, segment codes and BCD helpers for the three-digit countdown.
package bcd_pkg;

    localparam int unsigned DigitW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [6:0] SegD0    = 7'h7E;
    localparam logic [6:0] SegD1    = 7'h30;
    localparam logic [6:0] SegD2    = 7'h6D;
    localparam logic [6:0] SegD3    = 7'h79;
    localparam logic [6:0] SegD4    = 7'h33;
    localparam logic [6:0] SegD5    = 7'h5B;
    localparam logic [6:0] SegD6    = 7'h5F;
    localparam logic [6:0] SegD7    = 7'h70;
    localparam logic [6:0] SegD8    = 7'h7F;
    localparam logic [6:0] SegD9    = 7'h7B;
    localparam logic [6:0] SegBlank = 7'h00;

    function automatic logic is_bcd(input logic [11:0] v);
        return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] seg_encode(input logic [DigitW-1:0] d);
        case (d)
            4'd0:    return SegD0;
            4'd1:    return SegD1;
            4'd2:    return SegD2;
            4'd3:    return SegD3;
            4'd4:    return SegD4;
            4'd5:    return SegD5;
            4'd6:    return SegD6;
            4'd7:    return SegD7;
            4'd8:    return SegD8;
            4'd9:    return SegD9;
            default: return SegBlank;
        endcase
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of a down-counter; borrows are chained from units upward.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DigitW-1:0] load_val_i,
    input  logic              en_i,
    input  logic              borrow_i,
    output logic [DigitW-1:0] value_o,
    output logic              borrow_o
);

    logic [DigitW-1:0] value_q, value_d;
    logic              dec;

    assign dec      = en_i & borrow_i;
    assign borrow_o = dec && (value_q == '0);
    assign value_o  = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec) begin
            value_d = (value_q == '0) ? 4'd9 : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_999.sv
// Three-digit BCD down-counter with preset, run/pause, terminal pulse and 7-segment outputs.
module bcd_countdown_999
    import bcd_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] preset,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    output logic [11:0] q,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0,
    output logic        zero,
    output logic        done,
    output logic        busy,
    output logic        preset_err
);

    state_e      state_q, state_d;
    logic [11:0] preset_q, preset_d;
    logic        done_q, done_d;
    logic        perr_q, perr_d;

    logic        dig_load;
    logic [11:0] load_val;
    logic        dec_en;
    logic        b_units, b_tens, b_hund;

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        done_d   = 1'b0;
        perr_d   = perr_q;
        dig_load = 1'b0;
        load_val = preset;
        dec_en   = 1'b0;
        if (load) begin
            if (is_bcd(preset)) begin
                dig_load = 1'b1;
                preset_d = preset;
                perr_d   = 1'b0;
                state_d  = StIdle;
            end else begin
                perr_d = 1'b1;
            end
        end else if (stop) begin
            state_d = StIdle;
        end else if (start && state_q == StIdle) begin
            if (q != 12'h000 || (AUTO_RELOAD && preset_q != 12'h000)) begin
                state_d = StRun;
            end
        end else if (tick && state_q == StRun) begin
            if (q == 12'h000) begin
                // Only reachable with auto-reload: the tick after 000 restores the preset.
                if (AUTO_RELOAD) begin
                    dig_load = 1'b1;
                    load_val = preset_q;
                end
            end else begin
                dec_en = 1'b1;
                if (q == 12'h001) begin
                    done_d = 1'b1;
                    if (!AUTO_RELOAD) begin
                        state_d = StDone;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            preset_q <= 12'h000;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
        end
    end

    bcd_down_digit u_units (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dig_load),
        .load_val_i (load_val[3:0]),
        .en_i       (dec_en),
        .borrow_i   (1'b1),
        .value_o    (q[3:0]),
        .borrow_o   (b_units)
    );

    bcd_down_digit u_tens (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dig_load),
        .load_val_i (load_val[7:4]),
        .en_i       (dec_en),
        .borrow_i   (b_units),
        .value_o    (q[7:4]),
        .borrow_o   (b_tens)
    );

    bcd_down_digit u_hund (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dig_load),
        .load_val_i (load_val[11:8]),
        .en_i       (dec_en),
        .borrow_i   (b_tens),
        .value_o    (q[11:8]),
        .borrow_o   (b_hund)
    );

    // Count never wraps below 000, so the top borrow is intentionally unused.
    logic unused_borrow;
    assign unused_borrow = b_hund;

    assign seg2       = seg_encode(q[11:8]);
    assign seg1       = seg_encode(q[7:4]);
    assign seg0       = seg_encode(q[3:0]);
    assign zero       = (q == 12'h000);
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign preset_err = perr_q;

endmodule

// File: tb/tb_bcd_countdown_999.sv
// Directed bench for the BCD countdown, covering both plain and auto-reload builds.
module tb_bcd_countdown_999;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, start, stop, tick;
    logic [11:0] preset;

    logic [11:0] q, q_ar;
    logic [6:0]  seg2, seg1, seg0, seg2_ar, seg1_ar, seg0_ar;
    logic        zero, done, busy, perr;
    logic        zero_ar, done_ar, busy_ar, perr_ar;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_countdown_999 #(.AUTO_RELOAD(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .preset     (preset),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .q          (q),
        .seg2       (seg2),
        .seg1       (seg1),
        .seg0       (seg0),
        .zero       (zero),
        .done       (done),
        .busy       (busy),
        .preset_err (perr)
    );

    bcd_countdown_999 #(.AUTO_RELOAD(1'b1)) dut_ar (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .preset     (preset),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .q          (q_ar),
        .seg2       (seg2_ar),
        .seg1       (seg1_ar),
        .seg0       (seg0_ar),
        .zero       (zero_ar),
        .done       (done_ar),
        .busy       (busy_ar),
        .preset_err (perr_ar)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then release.
    task automatic cyc(input logic ld, input logic [11:0] pre, input logic st,
                       input logic sp, input logic tk);
        load   = ld;
        preset = pre;
        start  = st;
        stop   = sp;
        tick   = tk;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    logic [11:0] cd_exp [12] = '{12'h011, 12'h010, 12'h009, 12'h008, 12'h007, 12'h006,
                                 12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};
    logic [11:0] ar_q   [6]  = '{12'h001, 12'h000, 12'h002, 12'h001, 12'h000, 12'h002};
    logic        ar_done[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int done_cnt;
        rst = 1'b1; load = 0; start = 0; stop = 0; tick = 0; preset = '0;

        // Reset with random inputs
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load   = 1'($urandom);
            start  = 1'($urandom);
            stop   = 1'($urandom);
            tick   = 1'($urandom);
            preset = 12'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b1; load = 0; start = 0; stop = 0; tick = 0;
        check("rst_q", q, 12'h000);
        check("rst_seg2", seg2, 7'h7E);
        check("rst_seg1", seg1, 7'h7E);
        check("rst_seg0", seg0, 7'h7E);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_perr", perr, 0);

        // Countdown from 012
        cyc(1, 12'h012, 0, 0, 0);
        check("cd_load_q", q, 12'h012);
        check("cd_load_busy", busy, 0);
        check("cd_load_zero", zero, 0);
        cyc(0, 12'h000, 1, 0, 0);
        check("cd_start_busy", busy, 1);
        check("cd_start_q", q, 12'h012);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 12'h000, 0, 0, 1);
            check($sformatf("cd_q%0d", i), q, cd_exp[i]);
            check($sformatf("cd_done%0d", i), done, (i == 11) ? 1 : 0);
            if (done) done_cnt++;
        end
        check("cd_done_count", done_cnt, 1);
        check("cd_zero", zero, 1);
        check("cd_state_done", busy, 0);
        cyc(0, 12'h000, 0, 0, 1);
        check("cd_hold_q", q, 12'h000);
        check("cd_hold_done", done, 0);

        // Borrow across digits
        cyc(1, 12'h100, 0, 0, 0);
        cyc(0, 12'h000, 1, 0, 0);
        cyc(0, 12'h000, 0, 0, 1);
        check("br_q", q, 12'h099);
        check("br_seg2", seg2, 7'h7E);
        check("br_seg1", seg1, 7'h7B);
        check("br_seg0", seg0, 7'h7B);
        cyc(1, 12'h010, 0, 0, 0);
        cyc(0, 12'h000, 1, 0, 0);
        cyc(0, 12'h000, 0, 0, 1);
        check("br2_q", q, 12'h009);

        // Invalid preset keeps count and state
        cyc(1, 12'h250, 0, 0, 0);
        cyc(0, 12'h000, 1, 0, 0);
        cyc(1, 12'h1A3, 0, 0, 1);
        check("inv_perr", perr, 1);
        check("inv_q", q, 12'h250);
        check("inv_busy", busy, 1);
        cyc(1, 12'h005, 0, 0, 0);
        check("inv_clr_perr", perr, 0);
        check("inv_clr_q", q, 12'h005);
        check("inv_clr_busy", busy, 0);

        // Pause and priority
        cyc(1, 12'h008, 0, 0, 0);
        cyc(0, 12'h000, 1, 0, 0);
        cyc(0, 12'h000, 0, 0, 1);
        check("pp_q7", q, 12'h007);
        cyc(0, 12'h000, 0, 1, 1);
        check("pp_stop_q", q, 12'h007);
        check("pp_stop_busy", busy, 0);
        cyc(0, 12'h000, 1, 0, 1);
        check("pp_start_q", q, 12'h007);
        check("pp_start_busy", busy, 1);
        cyc(0, 12'h000, 0, 0, 1);
        check("pp_q6", q, 12'h006);
        check("pp_seg0", seg0, 7'h5F);
        cyc(1, 12'h1A3, 0, 0, 1);
        check("pp_ld_tick_q", q, 12'h006);

        // Auto-reload build
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 12'h002, 0, 0, 0);
        cyc(0, 12'h000, 1, 0, 0);
        check("ar_busy", busy_ar, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 12'h000, 0, 0, 1);
            check($sformatf("ar_q%0d", i), q_ar, ar_q[i]);
            check($sformatf("ar_done%0d", i), done_ar, ar_done[i]);
            check($sformatf("ar_busy%0d", i), busy_ar, 1);
        end
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        tick = 1'b0;
        check("ar_rst_q", q_ar, 12'h000);
        check("ar_rst_busy", busy_ar, 0);
        check("ar_rst_zero", zero_ar, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
